// File: rtl/ioc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ioc_pkg
// Description : Width helper and 1 ms divider derivation for input_conditioner.
// Revision    : 1.0
// ============================================================================
package ioc_pkg;

   // Bits needed to hold `value` distinct states; never less than one bit.
   function automatic int clog2(input int value);
      int w = 1;
      while ((64'd1 << w) < 64'(value)) begin
         w++;
      end
      return w;
   endfunction

   // Clock cycles per millisecond.
   function automatic int ms_div(input int clk_frq);
      return clk_frq / 1000;
   endfunction

endpackage
`default_nettype wire

// File: rtl/input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner_if
// Description : Raw inputs and conditioned outputs of input_conditioner.
// Revision    : 1.0
// ============================================================================
interface input_conditioner_if #(
   parameter int C_CHANNELS = 8
);
   logic [C_CHANNELS-1:0] in;
   logic [C_CHANNELS-1:0] out;
   logic [C_CHANNELS-1:0] rise;
   logic [C_CHANNELS-1:0] fall;
   logic [C_CHANNELS-1:0] long;
   logic                  tick;
   logic                  heartbeat;

   modport master (
      output in,
      input  out, rise, fall, long, tick, heartbeat
   );

   modport slave (
      input  in,
      output out, rise, fall, long, tick, heartbeat
   );
endinterface
`default_nettype wire

// File: rtl/ioc_channel.sv
`default_nettype none
// ============================================================================
// Module      : ioc_channel
// Description : One input: synchroniser, tick-based debounce, edge and
//               long-press pulses.
// Revision    : 1.0
// ============================================================================
module ioc_channel
   import ioc_pkg::*;
#(
   parameter int C_INTERVAL = 10,
   parameter int C_LONG_MS  = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_tick,
   input  logic i_in,
   output logic o_out,
   output logic o_rise,
   output logic o_fall,
   output logic o_long
);
   localparam int c_deb_w  = clog2(C_INTERVAL);
   localparam int c_long_w = clog2(C_LONG_MS + 1);
   localparam logic [c_deb_w-1:0]  c_deb_last = c_deb_w'(C_INTERVAL - 1);
   localparam logic [c_long_w-1:0] c_long_max = c_long_w'(C_LONG_MS);

   logic                sync1_q, sync1_d;
   logic                sync2_q, sync2_d;
   logic                out_q, out_d;
   logic [c_deb_w-1:0]  deb_cnt_q, deb_cnt_d;
   logic                rise_q, rise_d;
   logic                fall_q, fall_d;
   logic [c_long_w-1:0] long_cnt_q, long_cnt_d;
   logic                long_q, long_d;

   always_comb begin
      sync1_d    = i_in;
      sync2_d    = sync1_q;
      out_d      = out_q;
      deb_cnt_d  = deb_cnt_q;
      long_cnt_d = long_cnt_q;
      long_d     = 1'b0;

      // Any cycle agreeing with the current level restarts the interval.
      if (sync2_q == out_q) begin
         deb_cnt_d = '0;
      end else if (i_tick) begin
         if (deb_cnt_q == c_deb_last) begin
            out_d     = sync2_q;
            deb_cnt_d = '0;
         end else begin
            deb_cnt_d = deb_cnt_q + c_deb_w'(1);
         end
      end

      rise_d = out_d & ~out_q;
      fall_d = ~out_d & out_q;

      // Saturation at the threshold keeps a held press from re-firing.
      if (!out_q) begin
         long_cnt_d = '0;
      end else if (i_tick && (long_cnt_q != c_long_max)) begin
         long_cnt_d = long_cnt_q + c_long_w'(1);
         long_d     = (long_cnt_q == (c_long_max - c_long_w'(1)));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         out_q      <= 1'b0;
         deb_cnt_q  <= '0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         long_cnt_q <= '0;
         long_q     <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         out_q      <= out_d;
         deb_cnt_q  <= deb_cnt_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         long_cnt_q <= long_cnt_d;
         long_q     <= long_d;
      end
   end

   assign o_out  = out_q;
   assign o_rise = rise_q;
   assign o_fall = fall_q;
   assign o_long = long_q;

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner
// Description : Debounces C_CHANNELS switch inputs on a shared 1 ms tick and
//               provides edge/long-press pulses plus a heartbeat.
// Revision    : 1.0
// ============================================================================
module input_conditioner
   import ioc_pkg::*;
#(
   parameter int C_CLK_FRQ  = 100_000_000,
   parameter int C_CHANNELS = 8,
   parameter int C_INTERVAL = 10,
   parameter int C_LONG_MS  = 1000,
   parameter int C_HB_BITS  = 24
) (
   input  logic               clk,
   input  logic               rst,
   input_conditioner_if.slave bus
);
   localparam int c_presc_div = ms_div(C_CLK_FRQ);
   localparam int c_presc_w   = clog2(c_presc_div);
   localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(c_presc_div - 1);

   logic [c_presc_w-1:0]  presc_q, presc_d;
   logic                  tick_q, tick_d;
   logic [C_HB_BITS-1:0]  hb_q, hb_d;

   logic [C_CHANNELS-1:0] chan_out;
   logic [C_CHANNELS-1:0] chan_rise;
   logic [C_CHANNELS-1:0] chan_fall;
   logic [C_CHANNELS-1:0] chan_long;

   always_comb begin
      tick_d  = (presc_q == c_presc_last);
      presc_d = tick_d ? '0 : presc_q + c_presc_w'(1);
      hb_d    = hb_q + C_HB_BITS'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
         hb_q    <= '0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
         hb_q    <= hb_d;
      end
   end

   // Every channel sees the same registered tick so simultaneous presses
   // complete in the same cycle.
   for (genvar gi = 0; gi < C_CHANNELS; gi++) begin : g_channel
      ioc_channel #(
         .C_INTERVAL (C_INTERVAL),
         .C_LONG_MS  (C_LONG_MS)
      ) u_channel (
         .clk    (clk),
         .rst    (rst),
         .i_tick (tick_q),
         .i_in   (bus.in[gi]),
         .o_out  (chan_out[gi]),
         .o_rise (chan_rise[gi]),
         .o_fall (chan_fall[gi]),
         .o_long (chan_long[gi])
      );
   end

   assign bus.out       = chan_out;
   assign bus.rise      = chan_rise;
   assign bus.fall      = chan_fall;
   assign bus.long      = chan_long;
   assign bus.tick      = tick_q;
   assign bus.heartbeat = hb_q[C_HB_BITS-1];

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_conditioner
// Description : Scoreboard bench for input_conditioner (P=10, 4 channels).
// Revision    : 1.0
// ============================================================================
module tb_input_conditioner;
   localparam int K_RISE = 0;
   localparam int K_FALL = 1;
   localparam int K_LONG = 2;

   typedef struct {
      int         kind;
      logic [3:0] mask;
      int         lo;
      int         hi;
      bit         rel;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   last_rise [4] = '{0, 0, 0, 0};
   exp_t exp_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   input_conditioner_if #(.C_CHANNELS(4)) bus ();

   input_conditioner #(
      .C_CLK_FRQ  (10_000),
      .C_CHANNELS (4),
      .C_INTERVAL (3),
      .C_LONG_MS  (5),
      .C_HB_BITS  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check_eq(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic expect_ev(input int kind, input logic [3:0] mask, input int lo, input int hi,
                            input bit rel);
      exp_t e;
      e.kind = kind; e.mask = mask; e.lo = lo; e.hi = hi; e.rel = rel;
      exp_q.push_back(e);
   endtask

   task automatic check_kind(input int kind, input logic [3:0] v);
      exp_t e;
      int   lo, hi, base;
      if (v != 4'b0) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: kind=%0d mask=%b at cycle %0d, required none",
                     kind, v, cyc);
         end else begin
            e = exp_q.pop_front();
            base = 0;
            if (e.rel) begin
               for (int i = 3; i >= 0; i--) if (e.mask[i]) base = last_rise[i];
            end
            lo = base + e.lo;
            hi = base + e.hi;
            if (e.kind != kind || e.mask != v || cyc < lo || cyc > hi) begin
               n_fail++;
               $display("FAIL event: kind=%0d mask=%b at cycle %0d, required kind=%0d mask=%b cycles %0d..%0d",
                        kind, v, cyc, e.kind, e.mask, lo, hi);
            end
         end
         if (kind == K_RISE) begin
            for (int i = 0; i < 4; i++) if (v[i]) last_rise[i] = cyc;
         end
      end
   endtask

   // Monitor: every pulse seen on the outputs must match the next expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            check_kind(K_RISE, bus.rise);
            check_kind(K_FALL, bus.fall);
            check_kind(K_LONG, bus.long);
            if ((bus.rise | bus.fall) != 4'b0) begin
               n_checks++;
               if ((bus.rise & bus.fall) != 4'b0) begin
                  n_fail++;
                  $display("FAIL rise_fall_overlap: rise=%b fall=%b, required disjoint",
                           bus.rise, bus.fall);
               end
            end
         end
      end
   end

   task automatic drain(input string name, input int budget);
      int b = budget;
      while (exp_q.size() != 0 && b > 0) begin
         @(negedge clk);
         b--;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d expected events outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic press(input logic [3:0] v, input int kind, input logic [3:0] mask);
      bus.in = v;
      expect_ev(kind, mask, cyc + 23, cyc + 32, 1'b0);
   endtask

   initial begin
      bus.in = 4'b0;
      rst    = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("reset_out",  {4'b0, bus.out},  8'h00);
      check_eq("reset_rise", {4'b0, bus.rise}, 8'h00);
      check_eq("reset_fall", {4'b0, bus.fall}, 8'h00);
      check_eq("reset_long", {4'b0, bus.long}, 8'h00);
      check_eq("reset_tick_hb", {6'b0, bus.tick, bus.heartbeat}, 8'h00);

      // Free run: tick on every 10th cycle, heartbeat toggles every 8.
      rst = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         check_eq("freerun_tick", {7'b0, bus.tick}, {7'b0, (i % 10) == 0});
         check_eq("freerun_hb", {7'b0, bus.heartbeat}, {7'b0, (i % 16) >= 8});
      end

      // Single press and release on channel 0.
      press(4'b0001, K_RISE, 4'b0001);
      drain("ch0_rise", 60);
      check_eq("ch0_out_high", {4'b0, bus.out}, 8'h01);
      press(4'b0000, K_FALL, 4'b0001);
      drain("ch0_fall", 60);

      // A 15-cycle glitch on channel 1 is filtered out.
      bus.in = 4'b0010;
      repeat (15) @(negedge clk);
      bus.in = 4'b0000;
      repeat (60) @(negedge clk);
      check_eq("ch1_glitch_out", {4'b0, bus.out}, 8'h00);

      // Long press on channel 2: one long pulse, no repeat after release.
      press(4'b0100, K_RISE, 4'b0100);
      expect_ev(K_LONG, 4'b0100, 41, 50, 1'b1);
      repeat (200) @(negedge clk);
      drain("ch2_long", 0);
      check_eq("ch2_out_held", {4'b0, bus.out}, 8'h04);
      press(4'b0000, K_FALL, 4'b0100);
      drain("ch2_fall", 60);
      repeat (100) @(negedge clk);
      check_eq("ch2_out_low", {4'b0, bus.out}, 8'h00);

      // All channels together.
      press(4'b1111, K_RISE, 4'b1111);
      drain("all_rise", 60);
      check_eq("all_out_high", {4'b0, bus.out}, 8'h0F);
      press(4'b0000, K_FALL, 4'b1111);
      drain("all_fall", 60);

      // Reset in the middle of a debounce with two ticks already counted.
      begin
         int b = 0;
         while (!bus.tick && b < 30) begin
            @(negedge clk);
            b++;
         end
      end
      check_eq("rst_tick_align", {7'b0, bus.tick}, 8'h01);
      bus.in = 4'b0001;
      repeat (25) @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("rst_async_out",  {4'b0, bus.out},  8'h00);
      check_eq("rst_async_pulses", {4'b0, bus.rise | bus.fall | bus.long}, 8'h00);
      check_eq("rst_async_tick_hb", {6'b0, bus.tick, bus.heartbeat}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      expect_ev(K_RISE, 4'b0001, cyc + 23, cyc + 32, 1'b0);
      drain("rst_rise", 60);
      check_eq("rst_out_high", {4'b0, bus.out}, 8'h01);
      press(4'b0000, K_FALL, 4'b0001);
      drain("rst_fall", 60);
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter C_CLK_FRQ, default 100_000_000, system clock frequency [Hz]; integer multiple of 1000.
REQ-002 SHALL have parameter C_CHANNELS, default 8, number of conditioned inputs (1..32).
REQ-003 SHALL have parameter C_INTERVAL, default 10, debounce interval [ms] (>=1).
REQ-004 SHALL have parameter C_LONG_MS, default 1000, long-press threshold [ms] (>=1).
REQ-005 SHALL have parameter C_HB_BITS, default 24, heartbeat counter width (>=2).
REQ-006 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port in  input  C_CHANNELS  raw asynchronous switch/button lines.
REQ-009 SHALL have port out  output  C_CHANNELS  debounced levels.
REQ-010 SHALL have port rise  output  C_CHANNELS  one-cycle pulse per debounced 0->1.
REQ-011 SHALL have port fall  output  C_CHANNELS  one-cycle pulse per debounced 1->0.
REQ-012 SHALL have port long  output  C_CHANNELS  one-cycle pulse per long press.
REQ-013 SHALL have port tick  output  1  one-cycle 1 ms timebase pulse.
REQ-014 SHALL have port heartbeat  output  1  MSB of free-running counter.

Function
REQ-015 Prescaler SHALL count 0..C_CLK_FRQ/1000-1, asserting tick for one cycle at terminal count, then wrapping to 0.
REQ-016 Each in[i] SHALL pass a 2-flop synchroniser; sync[i] is its output.
REQ-017 Per channel, any cycle with sync[i]==out[i] SHALL clear the debounce counter to 0.
REQ-018 On a tick with sync[i]!=out[i]: counter SHALL increment, or, if already C_INTERVAL-1, out[i]<=sync[i] and counter<=0.
REQ-019 Resulting latency from stable in edge to out change SHALL be 2+(C_INTERVAL-1)*P+1 .. 2+C_INTERVAL*P cycles, P=C_CLK_FRQ/1000.
REQ-020 Input pulses/glitches not covering C_INTERVAL consecutive ticks SHALL leave out unchanged.
REQ-021 rise[i]/fall[i] SHALL be high exactly in the first cycle out[i] shows the new level; never both high.
REQ-022 Long counter SHALL clear when out[i]=0, increment on each tick while out[i]=1, saturating at C_LONG_MS.
REQ-023 long[i] SHALL pulse once, on the tick where the long counter reaches C_LONG_MS; no repeat until release and new press.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-025 Heartbeat counter SHALL increment every cycle, wrapping at 2^C_HB_BITS; heartbeat = its MSB.
REQ-026 Counter widths SHALL be clog2-sized from parameters; no truncation at maximum parameter values.

Reset
REQ-027 rst SHALL asynchronously clear synchronisers, prescaler, all counters, out, rise, fall, long, tick, heartbeat to 0.
REQ-028 rst SHALL take priority over every other event, including a coinciding tick or debounce completion.
REQ-029 After rst deassertion, a channel whose in is held high SHALL debounce normally and emit one rise.
REQ-030 No rise/fall/long pulse SHALL be generated by reset assertion or deassertion itself.

Structure
REQ-031 A shared package/header ioc_pkg SHALL hold the clog2 function and the ms-divider constant derivation.
REQ-032 Per-channel logic SHALL live in sub-module ioc_channel (synchroniser, debounce, edge, long-press), instantiated C_CHANNELS times by generate; prescaler and heartbeat stay in the top.

Verification (C_CLK_FRQ=10_000 so P=10, C_CHANNELS=4, C_INTERVAL=3, C_LONG_MS=5, C_HB_BITS=4)
REQ-033 in[0] 0->1 held -> out[0]=1 within 23..32 cycles, rise[0] exactly one cycle, other channels idle.
REQ-034 in[1] high 15 cycles then low -> out[1], rise[1], fall[1] stay 0 throughout.
REQ-035 in[2] held high 200 cycles -> long[2] single pulse 41..50 cycles after rise[2]; release -> fall[2] after debounce, no further long.
REQ-036 in[3:0] all toggled same cycle -> rise[3:0]=4'b1111 in one cycle; later simultaneous release -> fall=4'b1111 in one cycle.
REQ-037 rst asserted mid-debounce (in[0] high, 2 ticks counted) -> all outputs 0 immediately; after release out[0] needs full 23..32 cycles again.
REQ-038 Free run 40 cycles after reset -> tick every 10 cycles, heartbeat toggles every 8 cycles.
